wb_cmd_initiator: RTL and testbench

Wishbone classic single-transfer initiator. It converts a valid/ready command stream into one Wishbone read or write per command and returns the result on a valid/ready response port. It drives peripherals such as the system controller (version, nmi_vec, timer, seven-segment registers) from a test sequencer, boot loader or debug bridge. A timeout reports an error when a slave never acknowledges.

---
 rtl/wb_cmd_initiator.sv | 157 +++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes one
// Wishbone read or write, and the outcome is returned on a valid/ready response port.
module wb_cmd_initiator #(
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_we,
    input  logic [ADR_W-1:0] i_cmd_adr,
    input  logic [31:0]      i_cmd_dat,
    input  logic [3:0]       i_cmd_sel,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_dat,
    output logic             o_rsp_err,
    output logic             o_busy,
    output logic [ADR_W-1:0] o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic               we_q, we_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            adr_q       <= {ADR_W{1'b0}};
            dat_q       <= 32'h0000_0000;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic: everything holds unless a transition below changes it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    adr_d   = i_cmd_adr;
                    dat_d   = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    we_d    = i_cmd_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = BUS;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the last allowed cycle still succeeds
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0000_0000 : i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = 32'h0000_0000;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign o_cmd_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: vector table, directed corner sequences
// and randomized commands against a transaction-level memory model.
module tb_wb_cmd_initiator;

    localparam int ADR_W   = 32;
    localparam int TIMEOUT = 255;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic             i_cmd_we;
    logic [ADR_W-1:0] i_cmd_adr;
    logic [31:0]      i_cmd_dat;
    logic [3:0]       i_cmd_sel;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_dat;
    logic             o_rsp_err;
    logic             o_busy;
    logic [ADR_W-1:0] o_wb_adr;
    logic [31:0]      o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic             o_wb_we;
    logic             o_wb_cyc;
    logic             o_wb_stb;
    logic [31:0]      i_wb_rdt;
    logic             i_wb_ack;

    always #5 i_clk = ~i_clk;

    wb_cmd_initiator #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
        .o_busy(o_busy),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
    );

    // Slave: 16 words; ack_mode 0 = registered ack (ack<=cyc&stb&!ack), 1 = never, 2 = bench-driven
    logic [31:0] slv_mem [16] = '{default: 32'h0};
    logic        slv_ack = 1'b0;
    logic        man_ack;
    int          ack_mode;
    int          ack_seen = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign i_wb_ack = (ack_mode == 2) ? man_ack : slv_ack;
    assign i_wb_rdt = slv_mem[o_wb_adr[5:2]];

    always @(posedge i_clk) begin
        if (ack_mode == 0) begin
            slv_ack <= o_wb_cyc & o_wb_stb & ~slv_ack;
            if (o_wb_cyc && o_wb_stb && !slv_ack && o_wb_we)
                slv_mem[o_wb_adr[5:2]] <= merge(slv_mem[o_wb_adr[5:2]], o_wb_dat, o_wb_sel);
        end else begin
            slv_ack <= 1'b0;
        end
        if (i_wb_ack) ack_seen <= ack_seen + 1;
    end

    // Reference model: what the slave's memory should contain, updated per completed write
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int w;
        w = 0;
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_adr = adr; i_cmd_dat = dat; i_cmd_sel = sel;
        while (!o_cmd_ready && w < 50) begin @(negedge i_clk); w++; end
        check("cmd_ready_at_issue", {31'd0, o_cmd_ready}, 32'd1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int cyc_cnt, output bit rdy_hi);
        lat = 0; cyc_cnt = 0; rdy_hi = 1'b0;
        while (!o_rsp_valid && lat < 400) begin
            if (o_wb_cyc && o_wb_stb) cyc_cnt++;
            if (o_cmd_ready) rdy_hi = 1'b1;
            @(negedge i_clk);
            lat++;
        end
        check("rsp_arrived", {31'd0, o_rsp_valid}, 32'd1);
    endtask

    task automatic handshake(input int d);
        logic [31:0] dd;
        logic        ee;
        bit          bad;
        dd = o_rsp_dat; ee = o_rsp_err; bad = 1'b0;
        for (int i = 0; i < d; i++) begin
            @(negedge i_clk);
            if (!o_rsp_valid || o_rsp_dat !== dd || o_rsp_err !== ee || o_cmd_ready || o_wb_cyc) bad = 1'b1;
        end
        check("rsp_hold_stable", {31'd0, bad}, 32'd0);
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check("rsp_valid_after_hs", {31'd0, o_rsp_valid}, 32'd0);
        check("cmd_ready_after_hs", {31'd0, o_cmd_ready}, 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input int d, output logic [31:0] rd, output logic err,
                       output int lat, output int cyc_cnt, output bit rdy_hi);
        issue(we, adr, dat, sel);
        wait_rsp(lat, cyc_cnt, rdy_hi);
        rd = o_rsp_dat; err = o_rsp_err;
        handshake(d);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rd, exp;
        logic        err, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        int          lat, cyc_cnt, a0;
        bit          rdy_hi;

        vecs[0] = '{1'b1, 32'h0000_000C, 32'h8000_0100, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 32'h8000_0100, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h00FF_FFFF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h00FF_FFFF, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'hF, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 32'hAA22_CC44, 1'b0};

        ack_mode = 0; man_ack = 1'b0;
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_adr = 32'h0;
        i_cmd_dat = 32'h0; i_cmd_sel = 4'h0; i_rsp_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        check("rst_we", {31'd0, o_wb_we}, 32'd0);
        check("rst_adr", o_wb_adr, 32'h0);
        check("rst_dat", o_wb_dat, 32'h0);
        check("rst_sel", {28'd0, o_wb_sel}, 32'd0);
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_rsp_dat", o_rsp_dat, 32'h0);
        check("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);

        // Vector table against the registered-ack slave
        for (int i = 0; i < 7; i++) begin
            a0 = ack_seen;
            txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, i % 3, rd, err, lat, cyc_cnt, rdy_hi);
            check($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), lat, 32'd2);
            check($sformatf("vec%0d_cyc_cycles", i), cyc_cnt, 32'd2);
            check($sformatf("vec%0d_acks", i), ack_seen - a0, 32'd1);
            check($sformatf("vec%0d_ready_low", i), {31'd0, rdy_hi}, 32'd0);
            if (vecs[i].we) ref_mem[vecs[i].adr[5:2]] = merge(ref_mem[vecs[i].adr[5:2]], vecs[i].dat, vecs[i].sel);
        end

        // Response back-pressure with a second command waiting
        issue(1'b0, 32'h0000_000C, 32'h0, 4'hF);
        wait_rsp(lat, cyc_cnt, rdy_hi);
        check("bp_rsp_dat", o_rsp_dat, 32'h8000_0100);
        i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_adr = 32'h0000_0008;
        i_cmd_dat = 32'h1234_5678; i_cmd_sel = 4'hF;
        handshake(10);
        @(negedge i_clk);
        check("bp_next_accepted", {31'd0, o_wb_cyc}, 32'd1);
        check("bp_next_ready_low", {31'd0, o_cmd_ready}, 32'd0);
        i_cmd_valid = 1'b0;
        wait_rsp(lat, cyc_cnt, rdy_hi);
        check("bp_next_err", {31'd0, o_rsp_err}, 32'd0);
        handshake(0);
        ref_mem[2] = merge(ref_mem[2], 32'h1234_5678, 4'hF);

        // Timeout: ack never arrives
        ack_mode = 1;
        issue(1'b0, 32'h0000_0000, 32'h0, 4'hF);
        wait_rsp(lat, cyc_cnt, rdy_hi);
        check("to_cyc_cycles", cyc_cnt, TIMEOUT);
        check("to_lat", lat, TIMEOUT);
        check("to_err", {31'd0, o_rsp_err}, 32'd1);
        check("to_dat", o_rsp_dat, 32'h0);
        handshake(0);

        // Ack on the last allowed BUS cycle wins over timeout
        ack_mode = 2; man_ack = 1'b0;
        issue(1'b0, 32'h0000_000C, 32'h0, 4'hF);
        repeat (TIMEOUT - 1) @(negedge i_clk);
        check("late_cyc_still_high", {31'd0, o_wb_cyc}, 32'd1);
        man_ack = 1'b1;
        @(negedge i_clk);
        man_ack = 1'b0;
        check("late_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        check("late_err", {31'd0, o_rsp_err}, 32'd0);
        check("late_dat", o_rsp_dat, 32'h8000_0100);
        handshake(0);

        // Reset during BUS, then a stray ack
        issue(1'b0, 32'h0000_0000, 32'h0, 4'hF);
        check("mid_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mid_rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("mid_rst_stb", {31'd0, o_wb_stb}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("mid_rst_adr", o_wb_adr, 32'h0);
        man_ack = 1'b1;
        @(negedge i_clk);
        man_ack = 1'b0;
        check("stray_ack_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("stray_ack_busy", {31'd0, o_busy}, 32'd0);
        check("stray_ack_cyc", {31'd0, o_wb_cyc}, 32'd0);
        ack_mode = 0;
        @(negedge i_clk);

        // Randomized commands against the reference memory
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            we  = 1'($urandom_range(0, 1));
            adr = $urandom & 32'hFFFF_FFFC;
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            exp = we ? 32'h0 : ref_mem[adr[5:2]];
            txn(we, adr, dat, sel, $urandom_range(0, 3), rd, err, lat, cyc_cnt, rdy_hi);
            check($sformatf("rnd%0d_dat", n), rd, exp);
            check($sformatf("rnd%0d_err", n), {31'd0, err}, 32'd0);
            check($sformatf("rnd%0d_lat", n), lat, 32'd2);
            check($sformatf("rnd%0d_cyc_cycles", n), cyc_cnt, 32'd2);
            if (we) ref_mem[adr[5:2]] = merge(ref_mem[adr[5:2]], dat, sel);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
